regbus_master: RTL and testbench
================================

Name: regbus_master

Overview:
- Initiator for the team's register-file bus (valid/we/addr/data request, delayed valid plus combinational error/data response).
- Accepts one command at a time from an upstream bridge (UART/SPI command decoder or test sequencer) over a valid/ready handshake.
- Drives a single bus transaction, waits for read data with a timeout, and returns one response with status over a valid/ready handshake.
- Sits between the host bridge and the auto-generated register file.

Parameters:
ADDR_WIDTH, 10, register bus address width
DATA_WIDTH, 16, register bus data width
RD_TIMEOUT, 8, max cycles in RD_WAIT before a read is declared timed out (>=4)
TO_W, 4, width of timeout counter ($clog2(RD_TIMEOUT)+1)

Ports:
clk_i  in  1  clock
rst_i  in  1  reset, asynchronous, active-high
cmd_valid_i  in  1  command valid
cmd_ready_o  out  1  command accepted when both high
cmd_we_i  in  1  1=write, 0=read
cmd_addr_i  in  ADDR_WIDTH  target register address
cmd_wdata_i  in  DATA_WIDTH  write data
rsp_valid_o  out  1  response valid
rsp_ready_i  in  1  response consumed when both high
rsp_rdata_o  out  DATA_WIDTH  read data (0 for writes/failed reads)
rsp_status_o  out  2  00 OK, 01 DECERR, 10 TIMEOUT, 11 MISMATCH
bus_valid_o  out  1  to register file valid_i
bus_we_o  out  1  to register file we_i
bus_addr_o  out  ADDR_WIDTH  to register file addr_i
bus_wdata_o  out  DATA_WIDTH  to register file data_i
bus_valid_i  in  1  from register file valid_o (read data valid)
bus_error_i  in  1  from register file error_o (combinational on addr/we)
bus_rdata_i  in  DATA_WIDTH  from register file data_o (combinational on addr)
busy_o  out  1  high whenever state != IDLE

Behaviour:
- Reset (async, rst_i=1): state IDLE; cmd_ready_o=0 while in reset, then 1; all other outputs 0; timeout counter 0.
- States: IDLE, WR, RD_REQ, RD_WAIT, RSP.
- IDLE: cmd_ready_o=1. On handshake, register we/addr/wdata; go to WR (we=1) or RD_REQ (we=0).
- bus_addr_o and bus_wdata_o are held stable from acceptance until leaving RD_WAIT/WR (the responder's data/error are combinational on addr).
- WR: bus_valid_o=1, bus_we_o=1 for exactly one cycle. Sample bus_error_i the same cycle: 1 -> DECERR, else OK. Go to RSP.
- RD_REQ: bus_valid_o=1, bus_we_o=0 for exactly one cycle. Sample bus_error_i into a decerr flag. Go to RD_WAIT with counter=0.
- RD_WAIT: bus_valid_o=0; counter increments each cycle.
  - On bus_valid_i: capture bus_rdata_i; status = decerr ? DECERR : OK; go to RSP.
  - If counter==RD_TIMEOUT-1 without bus_valid_i: status TIMEOUT, rdata 0; go to RSP.
  - bus_valid_i in the same cycle as the timeout wins (data captured).
- RSP: rsp_valid_o=1 with rdata/status held stable until rsp_ready_i; then IDLE the next cycle. No new command is accepted in RSP (cmd_ready_o=0).
- Nominal latency (command accept at T):
  - Write: bus_valid at T+1, rsp_valid at T+2.
  - Read against a 3-stage responder: bus_valid at T+1, bus_valid_i at T+4, rsp_valid at T+5.
- bus_valid_i outside RD_WAIT (late response after timeout) is ignored; it must not corrupt the next transaction.
- DECERR reads still return the captured bus_rdata_i (0 from the register file).
- Reset mid-transaction: aborts immediately; no response is produced for the aborted command.

Optional Feature:
- Macro REGBUS_MASTER_RDBACK_EN.
- Defined: after a write with OK status, WR goes to RD_REQ/RD_WAIT with a verify flag, and compares read data to the written data masked by cmd_wdata_i width.
  - Mismatch -> MISMATCH (11), rsp_rdata_o = readback value.
  - Readback DECERR or TIMEOUT is reported as such.
  - Write latency becomes T+6.
- Undefined: writes respond directly from WR; status 11 is never produced.

Decomposition:
- Package regbus_pkg: state enum, status codes (ST_OK, ST_DECERR, ST_TIMEOUT, ST_MISMATCH), default ADDR_WIDTH/DATA_WIDTH.
- No sub-module needed; FSM, command register and timeout counter are in one module.
- The bench reuses the existing register file as the responder.

Test Plan:
- Write 0x1234 to 0x003 against the register file -> bus_valid/we 1 cycle at T+1; rsp at T+2 status 00; ram_addr_adc1 reads back 0x1234.
- Read 0x001 after reset -> rsp at T+5, rdata 0xBEEF, status 00.
- Write to 0x001 (read-only) and read 0x3FF -> status 01 for both; read rdata 0x0000.
- Responder stub never asserts valid -> status 10 after RD_TIMEOUT cycles. A late valid 2 cycles later is ignored, and a following read of 0x001 returns 0xBEEF.
- Hold rsp_ready_i=0 for 5 cycles with cmd_valid_i=1 -> rsp fields stable, cmd_ready_o=0, no second bus_valid_o; release -> next command accepted the cycle after.
- Assert rst_i during RD_WAIT -> all outputs 0 immediately, no response. With REGBUS_MASTER_RDBACK_EN and a stub returning the wrong data -> status 11.

Source files
------------

// File: rtl/regbus_pkg.sv
// regbus_pkg: shared definitions for the register-bus initiator.
//   - Default bus widths.
//   - FSM state codes (legacy-compatible localparams).
//   - Response status codes.
package regbus_pkg;

   localparam int unsigned DEF_ADDR_WIDTH = 10;
   localparam int unsigned DEF_DATA_WIDTH = 16;

   typedef logic [2:0] state_t;
   localparam state_t S_IDLE    = 3'd0;
   localparam state_t S_WR      = 3'd1;
   localparam state_t S_RD_REQ  = 3'd2;
   localparam state_t S_RD_WAIT = 3'd3;
   localparam state_t S_RSP     = 3'd4;

   typedef logic [1:0] status_t;
   localparam status_t ST_OK       = 2'b00;
   localparam status_t ST_DECERR   = 2'b01;
   localparam status_t ST_TIMEOUT  = 2'b10;
   localparam status_t ST_MISMATCH = 2'b11;

endpackage

// File: rtl/regbus_master.sv
// regbus_master: single-outstanding initiator for the register-file bus.
// Takes one command over a valid/ready handshake, runs one bus transaction (write, or read with
// a bounded wait for the delayed read-data valid) and returns one response with a status code.
//
// Optional feature (macro REGBUS_MASTER_RDBACK_EN): a write that completes OK is followed by a
// verify read of the same address; differing data is reported as ST_MISMATCH with the read value.
//
// Ports:
//   clk_i, rst_i                       clock, asynchronous active-high reset
//   cmd_valid_i/cmd_ready_o            command handshake
//   cmd_we_i, cmd_addr_i, cmd_wdata_i  command fields
//   rsp_valid_o/rsp_ready_i            response handshake
//   rsp_rdata_o, rsp_status_o          response fields (rdata 0 for writes/failed reads)
//   bus_valid_o, bus_we_o, bus_addr_o, bus_wdata_o   request to the register file
//   bus_valid_i, bus_error_i, bus_rdata_i            response from the register file
//   busy_o                             high whenever a command is in progress
module regbus_master
   import regbus_pkg::*;
#(
   parameter int unsigned ADDR_WIDTH = DEF_ADDR_WIDTH,
   parameter int unsigned DATA_WIDTH = DEF_DATA_WIDTH,
   parameter int unsigned RD_TIMEOUT = 8,
   parameter int unsigned TO_W       = $clog2(RD_TIMEOUT) + 1
) (
   input  logic                  clk_i,
   input  logic                  rst_i,
   input  logic                  cmd_valid_i,
   output logic                  cmd_ready_o,
   input  logic                  cmd_we_i,
   input  logic [ADDR_WIDTH-1:0] cmd_addr_i,
   input  logic [DATA_WIDTH-1:0] cmd_wdata_i,
   output logic                  rsp_valid_o,
   input  logic                  rsp_ready_i,
   output logic [DATA_WIDTH-1:0] rsp_rdata_o,
   output logic [1:0]            rsp_status_o,
   output logic                  bus_valid_o,
   output logic                  bus_we_o,
   output logic [ADDR_WIDTH-1:0] bus_addr_o,
   output logic [DATA_WIDTH-1:0] bus_wdata_o,
   input  logic                  bus_valid_i,
   input  logic                  bus_error_i,
   input  logic [DATA_WIDTH-1:0] bus_rdata_i,
   output logic                  busy_o
);

   localparam logic [TO_W-1:0] TO_LAST = TO_W'(RD_TIMEOUT - 1);

   state_t                state_q,  state_d;
   logic [ADDR_WIDTH-1:0] addr_q,   addr_d;
   logic [DATA_WIDTH-1:0] wdata_q,  wdata_d;
   logic [DATA_WIDTH-1:0] rdata_q,  rdata_d;
   status_t               status_q, status_d;
   logic                  decerr_q, decerr_d;
   logic [TO_W-1:0]       cnt_q,    cnt_d;
`ifdef REGBUS_MASTER_RDBACK_EN
   logic                  verify_q, verify_d;
`endif

   always_comb begin
      state_d  = state_q;
      addr_d   = addr_q;
      wdata_d  = wdata_q;
      rdata_d  = rdata_q;
      status_d = status_q;
      decerr_d = decerr_q;
      cnt_d    = cnt_q;
`ifdef REGBUS_MASTER_RDBACK_EN
      verify_d = verify_q;
`endif
      case (state_q)
         S_IDLE: begin
            if (cmd_valid_i) begin
               addr_d  = cmd_addr_i;
               wdata_d = cmd_wdata_i;
               state_d = cmd_we_i ? S_WR : S_RD_REQ;
`ifdef REGBUS_MASTER_RDBACK_EN
               verify_d = 1'b0;
`endif
            end
         end
         S_WR: begin
            // Error is combinational on addr/we, so it is valid in the request cycle.
            if (bus_error_i) begin
               status_d = ST_DECERR;
               rdata_d  = '0;
               state_d  = S_RSP;
            end else begin
`ifdef REGBUS_MASTER_RDBACK_EN
               verify_d = 1'b1;
               state_d  = S_RD_REQ;
`else
               status_d = ST_OK;
               rdata_d  = '0;
               state_d  = S_RSP;
`endif
            end
         end
         S_RD_REQ: begin
            decerr_d = bus_error_i;
            cnt_d    = '0;
            state_d  = S_RD_WAIT;
         end
         S_RD_WAIT: begin
            cnt_d = cnt_q + 1'b1;
            // Data arriving in the timeout cycle still wins.
            if (bus_valid_i) begin
               rdata_d  = bus_rdata_i;
               status_d = decerr_q ? ST_DECERR : ST_OK;
               state_d  = S_RSP;
`ifdef REGBUS_MASTER_RDBACK_EN
               if (verify_q) begin
                  if (!decerr_q && (bus_rdata_i != wdata_q)) begin
                     status_d = ST_MISMATCH;
                  end else begin
                     rdata_d = '0;
                  end
               end
`endif
            end else if (cnt_q == TO_LAST) begin
               rdata_d  = '0;
               status_d = ST_TIMEOUT;
               state_d  = S_RSP;
            end
         end
         S_RSP: begin
            if (rsp_ready_i) begin
               state_d = S_IDLE;
            end
         end
         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         state_q  <= S_IDLE;
         addr_q   <= '0;
         wdata_q  <= '0;
         rdata_q  <= '0;
         status_q <= ST_OK;
         decerr_q <= 1'b0;
         cnt_q    <= '0;
`ifdef REGBUS_MASTER_RDBACK_EN
         verify_q <= 1'b0;
`endif
      end else begin
         state_q  <= state_d;
         addr_q   <= addr_d;
         wdata_q  <= wdata_d;
         rdata_q  <= rdata_d;
         status_q <= status_d;
         decerr_q <= decerr_d;
         cnt_q    <= cnt_d;
`ifdef REGBUS_MASTER_RDBACK_EN
         verify_q <= verify_d;
`endif
      end
   end

   // Ready is masked by reset so the bridge sees 0 while reset is held.
   assign cmd_ready_o  = (state_q == S_IDLE) & ~rst_i;
   assign bus_valid_o  = (state_q == S_WR) | (state_q == S_RD_REQ);
   assign bus_we_o     = (state_q == S_WR);
   // Address/data come straight from the command register, stable for the whole transaction.
   assign bus_addr_o   = addr_q;
   assign bus_wdata_o  = wdata_q;
   assign rsp_valid_o  = (state_q == S_RSP);
   assign rsp_rdata_o  = rdata_q;
   assign rsp_status_o = status_q;
   assign busy_o       = (state_q != S_IDLE);

endmodule

// File: tb/tb_regbus_master.sv
// tb_regbus_master: directed bench for regbus_master with a behavioural register-file responder
// (3-stage read valid, combinational error/data) and a transaction-level reference model.
module tb_regbus_master;

   localparam int unsigned AW         = 10;
   localparam int unsigned DW         = 16;
   localparam int unsigned RD_TIMEOUT = 8;
   localparam int unsigned TO_W       = 4;
`ifdef REGBUS_MASTER_RDBACK_EN
   localparam bit RDBACK = 1'b1;
`else
   localparam bit RDBACK = 1'b0;
`endif
   localparam int WR_LAT = RDBACK ? 6 : 2;

   logic          clk;
   logic          rst;
   logic          cmd_valid, cmd_ready, cmd_we;
   logic [AW-1:0] cmd_addr;
   logic [DW-1:0] cmd_wdata;
   logic          rsp_valid, rsp_ready;
   logic [DW-1:0] rsp_rdata;
   logic [1:0]    rsp_status;
   logic          bus_valid_o, bus_we_o;
   logic [AW-1:0] bus_addr_o;
   logic [DW-1:0] bus_wdata_o;
   logic          bus_valid_i, bus_error_i;
   logic [DW-1:0] bus_rdata_i;
   logic          busy;

   regbus_master #(
      .ADDR_WIDTH(AW),
      .DATA_WIDTH(DW),
      .RD_TIMEOUT(RD_TIMEOUT),
      .TO_W      (TO_W)
   ) dut (
      .clk_i       (clk),
      .rst_i       (rst),
      .cmd_valid_i (cmd_valid),
      .cmd_ready_o (cmd_ready),
      .cmd_we_i    (cmd_we),
      .cmd_addr_i  (cmd_addr),
      .cmd_wdata_i (cmd_wdata),
      .rsp_valid_o (rsp_valid),
      .rsp_ready_i (rsp_ready),
      .rsp_rdata_o (rsp_rdata),
      .rsp_status_o(rsp_status),
      .bus_valid_o (bus_valid_o),
      .bus_we_o    (bus_we_o),
      .bus_addr_o  (bus_addr_o),
      .bus_wdata_o (bus_wdata_o),
      .bus_valid_i (bus_valid_i),
      .bus_error_i (bus_error_i),
      .bus_rdata_i (bus_rdata_i),
      .busy_o      (busy)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   int n_chk  = 0;
   int n_fail = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s at cycle %0d: got 0x%0h, expected 0x%0h", name, cyc, act, exp);
      end
   endtask

   // ---------------- responder: 16 registers, 0x001 read-only 0xBEEF ----------------
   // stub_mode: 0 normal, 1 never returns read valid, 2 returns corrupted data (xor 0x0F0F)
   int         stub_mode;
   logic       late_vld;
   logic       rf_init;
   logic [DW-1:0] rf_mem [16];
   logic [2:0] rf_pipe;
   logic       rf_mapped;

   assign rf_mapped   = (bus_addr_o < 10'd16);
   assign bus_error_i = !rf_mapped || (bus_we_o && (bus_addr_o == 10'd1));
   assign bus_rdata_i = rf_mapped ?
                        (rf_mem[bus_addr_o[3:0]] ^ ((stub_mode == 2) ? 16'h0F0F : 16'h0000)) :
                        16'h0000;
   assign bus_valid_i = (rf_pipe[2] && (stub_mode != 1)) || late_vld;

   always @(posedge clk) begin
      if (rf_init) begin
         for (int i = 0; i < 16; i++) rf_mem[i] <= 16'h0000;
         rf_mem[1] <= 16'hBEEF;
         rf_pipe   <= 3'b000;
      end else begin
         rf_pipe <= {rf_pipe[1:0], bus_valid_o && !bus_we_o};
         if (bus_valid_o && bus_we_o && !bus_error_i) rf_mem[bus_addr_o[3:0]] <= bus_wdata_o;
      end
   end

   // ---------------- reference model + per-cycle compare ----------------
   logic [DW-1:0] mdl_mem [16];
   bit            pend;
   int            m_acc, m_lat;
   bit            m_we, m_two;
   logic [AW-1:0] m_addr;
   logic [DW-1:0] m_wdata, m_rd;
   logic [1:0]    m_st;

   task automatic model_cmd(input bit we, input logic [AW-1:0] a, input logic [DW-1:0] wd);
      bit            mapped, dec;
      logic [DW-1:0] rb;
      mapped = (a < 10'd16);
      dec    = !mapped || (we && a == 10'd1);
      m_we = we; m_addr = a; m_wdata = wd; m_two = 1'b0;
      if (we) begin
         if (!dec) mdl_mem[a[3:0]] = wd;
         if (dec) begin
            m_lat = 2; m_st = 2'b01; m_rd = '0;
         end else if (!RDBACK) begin
            m_lat = 2; m_st = 2'b00; m_rd = '0;
         end else begin
            m_two = 1'b1;
            if (stub_mode == 1) begin
               m_lat = 3 + RD_TIMEOUT; m_st = 2'b10; m_rd = '0;
            end else begin
               rb    = (stub_mode == 2) ? (wd ^ 16'h0F0F) : wd;
               m_lat = 6;
               m_st  = (rb != wd) ? 2'b11 : 2'b00;
               m_rd  = (rb != wd) ? rb : '0;
            end
         end
      end else if (stub_mode == 1) begin
         m_lat = 2 + RD_TIMEOUT; m_st = 2'b10; m_rd = '0;
      end else begin
         m_lat = 5;
         m_st  = dec ? 2'b01 : 2'b00;
         m_rd  = dec ? '0 : (mdl_mem[a[3:0]] ^ ((stub_mode == 2) ? 16'h0F0F : 16'h0000));
      end
   endtask

   initial begin : compare
      bit was, exp_bv, exp_rv;
      for (int i = 0; i < 16; i++) mdl_mem[i] = 16'h0000;
      mdl_mem[1] = 16'hBEEF;
      pend = 1'b0;
      forever begin
         @(negedge clk);
         if (rst) begin
            check("rst_cmd_ready", cmd_ready, 0);
            check("rst_bus_valid", bus_valid_o, 0);
            check("rst_bus_we", bus_we_o, 0);
            check("rst_bus_addr", bus_addr_o, 0);
            check("rst_bus_wdata", bus_wdata_o, 0);
            check("rst_rsp_valid", rsp_valid, 0);
            check("rst_rsp_rdata", rsp_rdata, 0);
            check("rst_rsp_status", rsp_status, 0);
            check("rst_busy", busy, 0);
            pend = 1'b0;
         end else begin
            was = pend;
            check("cmd_ready", cmd_ready, !was);
            check("busy", busy, was);
            exp_bv = was && ((cyc == m_acc + 1) || (m_two && cyc == m_acc + 2));
            check("bus_valid", bus_valid_o, exp_bv);
            if (exp_bv) begin
               check("bus_addr", bus_addr_o, m_addr);
               check("bus_we", bus_we_o, m_we && (cyc == m_acc + 1));
               if (m_we) check("bus_wdata", bus_wdata_o, m_wdata);
            end
            exp_rv = was && (cyc >= m_acc + m_lat);
            check("rsp_valid", rsp_valid, exp_rv);
            if (exp_rv) begin
               check("rsp_rdata", rsp_rdata, m_rd);
               check("rsp_status", rsp_status, m_st);
               if (rsp_ready) pend = 1'b0;
            end else if (!was && cmd_valid) begin
               pend  = 1'b1;
               m_acc = cyc;
               model_cmd(cmd_we, cmd_addr, cmd_wdata);
            end
         end
      end
   end

   // ---------------- stimulus ----------------
   int t_acc, t_hs;

   task automatic issue(input bit we, input logic [AW-1:0] a, input logic [DW-1:0] wd);
      bit got;
      @(posedge clk); #1;
      cmd_valid = 1'b1; cmd_we = we; cmd_addr = a; cmd_wdata = wd;
      got = 1'b0;
      for (int k = 0; k < 60; k++) begin
         @(negedge clk);
         if (cmd_ready) begin
            got = 1'b1;
            break;
         end
      end
      if (!got) begin
         n_chk++; n_fail++;
         $display("FAIL cmd_accept_timeout at cycle %0d: got no ready, expected ready", cyc);
      end
      t_acc = cyc;
      @(posedge clk); #1;
      cmd_valid = 1'b0;
   endtask

   task automatic collect(input string name, input logic [DW-1:0] e_rd, input logic [1:0] e_st,
                          input int e_lat);
      bit got;
      got = 1'b0;
      for (int k = 0; k < 60; k++) begin
         if (rsp_valid && cyc > t_acc) begin
            got = 1'b1;
            break;
         end
         @(negedge clk);
      end
      if (!got) begin
         n_chk++; n_fail++;
         $display("FAIL %s_rsp_timeout at cycle %0d: got no rsp_valid, expected one", name, cyc);
         return;
      end
      check({name, "_rdata"}, rsp_rdata, e_rd);
      check({name, "_status"}, rsp_status, e_st);
      check({name, "_latency"}, cyc - t_acc, e_lat);
      if (rsp_ready) begin
         @(posedge clk); #1;
      end
   endtask

   initial begin : stim
      rst = 1'b1; rf_init = 1'b1; stub_mode = 0; late_vld = 1'b0;
      cmd_valid = 1'b0; cmd_we = 1'b0; cmd_addr = '0; cmd_wdata = '0; rsp_ready = 1'b1;
      repeat (2) @(posedge clk);
      #1 rf_init = 1'b0;
      @(posedge clk); #1 rst = 1'b0;
      @(negedge clk);
      check("post_reset_ready", cmd_ready, 1);

      // write, reads, decode errors
      issue(1'b1, 10'h003, 16'h1234); collect("wr_003", 16'h0000, 2'b00, WR_LAT);
      check("rf_reg3", rf_mem[3], 16'h1234);
      issue(1'b0, 10'h001, 16'h0000); collect("rd_001", 16'hBEEF, 2'b00, 5);
      issue(1'b0, 10'h003, 16'h0000); collect("rd_003", 16'h1234, 2'b00, 5);
      issue(1'b1, 10'h001, 16'h5555); collect("wr_ro", 16'h0000, 2'b01, 2);
      issue(1'b0, 10'h3FF, 16'h0000); collect("rd_3ff", 16'h0000, 2'b01, 5);

      // timeout, then a stray late valid must be ignored
      stub_mode = 1;
      issue(1'b0, 10'h002, 16'h0000); collect("rd_to", 16'h0000, 2'b10, 2 + RD_TIMEOUT);
      @(posedge clk); #1 late_vld = 1'b1;
      @(posedge clk); #1 late_vld = 1'b0;
      stub_mode = 0;
      issue(1'b0, 10'h001, 16'h0000); collect("rd_after_to", 16'hBEEF, 2'b00, 5);

      // response back-pressure with a pending command
      rsp_ready = 1'b0;
      issue(1'b0, 10'h001, 16'h0000); collect("rd_hold", 16'hBEEF, 2'b00, 5);
      @(posedge clk); #1;
      cmd_valid = 1'b1; cmd_we = 1'b1; cmd_addr = 10'h003; cmd_wdata = 16'h5A5A;
      repeat (4) @(posedge clk);
      #1;
      check("hold_rdata", rsp_rdata, 16'hBEEF);
      check("hold_ready", cmd_ready, 0);
      rsp_ready = 1'b1;
      t_hs = cyc;
      issue(1'b1, 10'h003, 16'h5A5A);
      check("hold_accept_delay", t_acc - t_hs, 1);
      collect("wr_after_hold", 16'h0000, 2'b00, WR_LAT);

      // reset in the middle of a read wait
      issue(1'b0, 10'h001, 16'h0000);
      @(posedge clk); #1;
      @(posedge clk); #1;
      check("pre_abort_busy", busy, 1);
      rst = 1'b1;
      #1;
      check("abort_busy", busy, 0);
      check("abort_cmd_ready", cmd_ready, 0);
      check("abort_rsp_valid", rsp_valid, 0);
      check("abort_bus_addr", bus_addr_o, 0);
      repeat (2) @(posedge clk);
      #1 rst = 1'b0;
      repeat (8) @(posedge clk);
      #1;
      check("abort_no_rsp", rsp_valid, 0);
      issue(1'b0, 10'h003, 16'h0000); collect("rd_after_abort", 16'h5A5A, 2'b00, 5);

`ifdef REGBUS_MASTER_RDBACK_EN
      stub_mode = 2;
      issue(1'b1, 10'h003, 16'h1111); collect("wr_mismatch", 16'h1E1E, 2'b11, 6);
      stub_mode = 0;
      issue(1'b1, 10'h004, 16'h00C3); collect("wr_verify_ok", 16'h0000, 2'b00, 6);
`endif

      repeat (3) @(posedge clk);
      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

   initial begin : watchdog
      #200000;
      $display("FAIL watchdog at cycle %0d: got no finish, expected end of test", cyc);
      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail + 1);
      $fatal(1);
   end

endmodule
